// File: rtl/shift_register_n.sv
// N-bit universal shift register with parallel load, clock inhibit and a
// word-completion tracker (shift counter, busy flag and done pulse).
module shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             cp1,
    input  logic             rst,
    input  logic             cp2,
    input  logic             pl,
    input  logic [WIDTH-1:0] p,
    input  logic             ds,
    input  logic             ds_r,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             saida,
    output logic             QB,
    output logic             saida_r,
    output logic [CW-1:0]    cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             done_next;

    always_ff @(posedge cp1) begin
        if (rst) begin
            q     <= '0;
            cnt   <= '0;
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            q     <= q_next;
            cnt   <= cnt_next;
            state <= state_next;
            done  <= done_next;
        end
    end

    // Load beats inhibit beats mode; the counter only advances while a word is active.
    always_comb begin
        q_next     = q;
        cnt_next   = cnt;
        state_next = state;
        done_next  = 1'b0;
        if (!pl) begin
            q_next     = p;
            cnt_next   = '0;
            state_next = ACTIVE;
        end else if (!cp2) begin
            unique case (mode)
                2'b00: q_next = q;
                2'b01: q_next = {q[WIDTH-2:0], ds};
                2'b10: q_next = {ds_r, q[WIDTH-1:1]};
                2'b11: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            endcase
            if (mode != 2'b00 && state == ACTIVE) begin
                cnt_next = cnt + CW'(1);
                if (cnt_next == CW'(WIDTH)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
        end
    end

    assign busy    = (state == ACTIVE);
    assign saida   = q[WIDTH-1];
    assign QB      = ~q[WIDTH-1];
    assign saida_r = q[0];

endmodule

// File: doc/shift_register_n.md
SHIFT_REGISTER_N -- requirements
Module: shift_register_n

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter: CW, $clog2(WIDTH+1), width of the shift counter.
REQ-003 SHALL provide port: cp1  in  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL provide port: rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL provide port: cp2  in  1  clock inhibit; high freezes the shift and count state.
REQ-006 SHALL provide port: pl  in  1  parallel load, active-low, synchronous.
REQ-007 SHALL provide port: p  in  WIDTH  parallel load data.
REQ-008 SHALL provide port: ds  in  1  serial input for shift-up, entering q[0].
REQ-009 SHALL provide port: ds_r  in  1  serial input for shift-down, entering q[WIDTH-1].
REQ-010 SHALL provide port: mode  in  2  operation select: 00 hold, 01 shift up, 10 shift down, 11 rotate up.
REQ-011 SHALL provide port: q  out  WIDTH  register contents.
REQ-012 SHALL provide port: saida  out  1  equals q[WIDTH-1].
REQ-013 SHALL provide port: QB  out  1  equals ~q[WIDTH-1].
REQ-014 SHALL provide port: saida_r  out  1  equals q[0].
REQ-015 SHALL provide port: cnt  out  CW  number of shifts since the last load.
REQ-016 SHALL provide port: busy  out  1  high from a load until WIDTH shifts have completed.
REQ-017 SHALL provide port: done  out  1  one-cycle pulse on word completion.

Function
REQ-018 SHALL apply priority per edge: rst > pl low > cp2 high > mode.
REQ-019 SHALL, on pl=0: set q<=p, cnt<=0, busy<=1 and done<=0, regardless of cp2 and mode.
REQ-020 SHALL, when cp2=1 and pl=1: hold q, cnt and busy, and set done<=0.
REQ-021 SHALL, in mode 00: hold q and cnt.
REQ-022 SHALL, in mode 01: set q <= {q[WIDTH-2:0], ds}.
REQ-023 SHALL, in mode 10: set q <= {ds_r, q[WIDTH-1:1]}.
REQ-024 SHALL, in mode 11: set q <= {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-025 SHALL count as a shift any cp1 edge with rst=0, pl=1, cp2=0 and mode != 00.
REQ-026 SHALL implement a two-state FSM: IDLE (busy=0) and ACTIVE (busy=1); a load moves either state to ACTIVE; ACTIVE returns to IDLE on the shift that makes cnt==WIDTH.
REQ-027 SHALL increment cnt by 1 per shift in ACTIVE only; cnt holds its value in IDLE (saturated at WIDTH, or 0 after reset).
REQ-028 SHALL assert done for exactly the one cycle following the edge on which cnt reaches WIDTH; done is 0 otherwise.
REQ-029 SHALL still shift q in IDLE when mode != 00, without changing cnt, busy or done.
REQ-030 SHALL treat a load on the same edge as the final shift as a load: cnt=0, busy=1, no done pulse.
REQ-031 SHALL drive saida, QB and saida_r combinationally from q, with no added latency.

Reset
REQ-032 SHALL, on rst=1 at a cp1 edge: set q=0, cnt=0, busy=0, done=0 (saida=0, QB=1, saida_r=0), overriding pl and cp2.
REQ-033 SHALL abort any word in progress on reset, with no done pulse; cnt resumes only after the next load.

Verification (WIDTH=8)
REQ-034 SHALL verify: rst pulse, then pl=0, p=8'b00110000 -> q=00110000, busy=1, cnt=0, saida=0, QB=1.
REQ-035 SHALL verify: after that load, mode=01, ds=0 for 2 edges -> q=11000000, saida=1, QB=0, cnt=2.
REQ-036 SHALL verify: continuing to 8 shifts -> q=00000000, cnt=8, busy=0, done high for exactly one cycle.
REQ-037 SHALL verify: load 8'hA5, set cp2=1 and mode=01 for 3 edges -> q=A5 and cnt=0 unchanged; then pl=0 with cp2=1 and p=8'h3C -> q=3C.
REQ-038 SHALL verify: load 8'h81, mode=11 for 8 edges -> q=81 and done pulses; mode=10, ds_r=1, one edge -> q=C0, saida_r=0.
REQ-039 SHALL verify: load 8'hFF, 4 shifts, then rst=1 -> q=0, cnt=0, busy=0, and no done pulse follows.
